present_decrypt: RTL and testbench

Iterative PRESENT-80 block decryptor, the inverse companion to the PRESENT-80 encryption core. It accepts a 64-bit ciphertext and an 80-bit key over a valid/ready handshake. It expands the key forward to the last round key, then runs 31 inverse rounds at one round per cycle and presents the plaintext on a valid/ready output. It sits beside the encryptor in the FPGA test top and closes the loop: encrypt, then decrypt, then compare.

---
 rtl/present_pkg.sv | 85 ++++++++
 rtl/present_key_step.sv | 37 +++
 rtl/present_decrypt.sv | 118 +++++++++++
 tb/tb_present_decrypt.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT-80 definitions for the encryption and
// decryption cores.
//   - ROUNDS, KEY_W : fixed cipher dimensions
//   - fsm_state_t   : controller state encoding
//   - key_dir_t     : key-schedule step direction
//   - sbox / inv_sbox, sbox_layer / inv_sbox_layer : 4-bit S-box and 64-bit layers
//   - p_layer / p_inv : bit permutation and its inverse
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int KEY_W  = 80;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        WHITEN,
        ROUND,
        DONE
    } fsm_state_t;

    typedef enum logic {
        KEY_FWD,
        KEY_INV
    } key_dir_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Destination of bit j under the PRESENT permutation; bit 63 is fixed.
    function automatic int p_pos(input int j);
        return (j == 63) ? 63 : (j * 16) % 63;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) begin
            y[p_pos(j)] = x[j];
        end
        return y;
    endfunction

    function automatic logic [63:0] p_inv(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) begin
            y[j] = x[p_pos(j)];
        end
        return y;
    endfunction

endpackage

// File: rtl/present_key_step.sv
// present_key_step: one combinational step of the PRESENT-80 key schedule.
//   key      in  80  current round key register
//   rc       in  5   round counter value for this step
//   dir      in  1   KEY_FWD: K(i) -> K(i+1); KEY_INV: K(i+1) -> K(i)
//   next_key out 80  updated key
module present_key_step
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       rc,
    input  key_dir_t         dir,
    output logic [KEY_W-1:0] next_key
);

    logic [KEY_W-1:0] fwd_rot;
    logic [KEY_W-1:0] inv_pre;

    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned, which would infer a latch.
        fwd_rot  = {key[18:0], key[79:19]};   // rotate left by 61
        inv_pre  = key;
        next_key = key;

        if (dir == KEY_FWD) begin
            next_key          = fwd_rot;
            next_key[79:76]   = sbox(fwd_rot[79:76]);
            next_key[19:15]   = fwd_rot[19:15] ^ rc;
        end else begin
            // Undo the forward step in reverse order: counter XOR, S-box, rotation.
            inv_pre[19:15]    = key[19:15] ^ rc;
            inv_pre[79:76]    = inv_sbox(key[79:76]);
            next_key          = {inv_pre[60:0], inv_pre[79:61]};   // rotate right by 61
        end
    end

endmodule

// File: rtl/present_decrypt.sv
// present_decrypt: iterative PRESENT-80 block decryptor, one round per cycle.
// The key is first run forward to K32, then 31 inverse rounds recover the
// plaintext. Fixed 63-cycle latency from accept to out_valid.
//   sys_clk       in  1   clock, rising edge
//   sys_rst       in  1   synchronous active-high reset, aborts any operation
//   in_valid      in  1   ciphertext/key offered
//   in_ready      out 1   idle, will accept (registered)
//   in_ciphertext in  64  ciphertext
//   in_key        in  80  user key
//   out_valid     out 1   plaintext available
//   out_ready     in  1   consumer accepts plaintext
//   out_plaintext out 64  recovered plaintext, held until the next block
module present_decrypt
    import present_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_ciphertext,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_plaintext
);

    fsm_state_t       fsm;
    logic [63:0]      state;
    logic [KEY_W-1:0] key;
    logic [4:0]       rc;

    key_dir_t         key_dir;
    logic [KEY_W-1:0] key_next;
    logic [63:0]      round_state;

    assign key_dir = (fsm == ROUND) ? KEY_INV : KEY_FWD;

    present_key_step u_key_step (
        .key      (key),
        .rc       (rc),
        .dir      (key_dir),
        .next_key (key_next)
    );

    // The inverse round consumes the key produced in this same cycle.
    assign round_state = inv_sbox_layer(p_inv(state)) ^ key_next[79:16];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // NOTE: the datapath registers are cleared too, so an aborted
            // block leaves no stale key, counter or plaintext behind.
            fsm           <= IDLE;
            state         <= '0;
            key           <= '0;
            rc            <= '0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_plaintext <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the register values from before this edge.
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= in_ciphertext;
                        key      <= in_key;
                        rc       <= 5'd1;
                        in_ready <= 1'b0;
                        fsm      <= KEYEXP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                KEYEXP: begin
                    key <= key_next;
                    if (rc == 5'(ROUNDS)) begin
                        fsm <= WHITEN;        // key now holds K32
                    end else begin
                        rc <= rc + 5'd1;
                    end
                end

                WHITEN: begin
                    state <= state ^ key[79:16];
                    rc    <= 5'(ROUNDS);
                    fsm   <= ROUND;
                end

                ROUND: begin
                    key   <= key_next;
                    state <= round_state;
                    if (rc == 5'd1) begin
                        out_plaintext <= round_state;
                        out_valid     <= 1'b1;
                        fsm           <= DONE;
                    end else begin
                        rc <= rc - 5'd1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end

                default: begin
                    fsm      <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_decrypt.sv
// tb_present_decrypt: directed bench for present_decrypt. Expected plaintexts
// go into a scoreboard queue when a block is sent and are compared when
// out_valid appears. Loopback vectors come from an independent encrypt model.
module tb_present_decrypt;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_ciphertext;
    logic [79:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_plaintext;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    present_decrypt dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ciphertext (in_ciphertext),
        .in_key        (in_key),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_plaintext (out_plaintext)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference encryptor ----------------
    function automatic logic [3:0] tb_s(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] tb_encrypt(input logic [63:0] pt, input logic [79:0] k);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] kk;
        int          p;
        s  = pt;
        kk = k;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = tb_s(s[4*n +: 4]);
            t = '0;
            for (int j = 0; j < 64; j++) begin
                p    = (j == 63) ? 63 : (j * 16) % 63;
                t[p] = s[j];
            end
            s  = t;
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = tb_s(kk[79:76]);
            kk[19:15] = kk[19:15] ^ 5'(r);
        end
        return s ^ kk[79:16];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        cyc++;
    endtask

    // Waits (bounded) for in_ready, offers one block, returns at the negedge
    // after the accept edge with cyc = 0.
    task automatic send(input logic [63:0] ct, input logic [79:0] k);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        check("send_in_ready", 64'(in_ready), 64'd1);
        in_valid      = 1'b1;
        in_ciphertext = ct;
        in_key        = k;
        tick();
        in_valid = 1'b0;
        cyc      = 0;
    endtask

    // Waits (bounded) for out_valid, checks latency and data against the
    // scoreboard, optionally stalls out_ready while offering a stray block.
    task automatic receive(input int hold, input bit spam);
        int          w;
        logic [63:0] exp;
        w   = 0;
        exp = '0;
        while (out_valid !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        check("latency", 64'(cyc), 64'd63);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check("plaintext", out_plaintext, exp);
        in_valid      = spam;
        in_ciphertext = 64'hDEAD_BEEF_0BAD_F00D;
        in_key        = 80'h1234_5678_9ABC_DEF0_1357;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_plaintext", out_plaintext, exp);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_plaintext", out_plaintext, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] pt;
        logic [95:0] rnd;
        int          rises;

        sys_rst       = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        in_ciphertext = '0;
        in_key        = '0;
        tick();
        tick();
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_plaintext", out_plaintext, 64'd0);
        sys_rst = 1'b0;
        tick();
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Published PRESENT-80 vectors.
        send(64'h5579C1387B228445, 80'h0);
        exp_q.push_back(64'h0000000000000000);
        receive(0, 1'b0);

        send(64'hE72C46C0F5945049, {80{1'b1}});
        exp_q.push_back(64'h0000000000000000);
        receive(0, 1'b0);

        send(64'hA112FFC72F68417B, 80'h0);
        exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
        receive(0, 1'b0);

        // Backpressure with a stray offer, then a back-to-back block.
        send(64'h3333DCD3213210D2, {80{1'b1}});
        exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
        receive(20, 1'b1);
        send(64'h5579C1387B228445, 80'h0);
        exp_q.push_back(64'h0000000000000000);
        receive(0, 1'b0);

        // Loopback: encrypt with the reference model, decrypt with the DUT.
        for (int i = 0; i < 3; i++) begin
            pt  = {$urandom, $urandom};
            rnd = {$urandom, $urandom, $urandom};
            send(tb_encrypt(pt, rnd[79:0]), rnd[79:0]);
            exp_q.push_back(pt);
            receive(0, 1'b0);
        end

        // Reset at E40 aborts the block; no output may appear afterwards.
        send(64'hA112FFC72F68417B, 80'h0);
        while (cyc < 39) tick();
        sys_rst = 1'b1;
        tick();
        check("abort_reset_out_valid", 64'(out_valid), 64'd0);
        check("abort_reset_in_ready", 64'(in_ready), 64'd0);
        sys_rst = 1'b0;
        tick();
        check("abort_in_ready", 64'(in_ready), 64'd1);
        rises = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid === 1'b1) rises++;
        end
        check("abort_no_output", 64'(rises), 64'd0);

        // Fresh block after the abort.
        send(64'hE72C46C0F5945049, {80{1'b1}});
        exp_q.push_back(64'h0000000000000000);
        receive(0, 1'b0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
